// File: rtl/sdram_arbit_rr.sv
`default_nettype none
// ============================================================================
// sdram_arbit_rr : refresh-priority, round-robin SDRAM command arbiter and mux
// Revision 1.0 - initial release
// ============================================================================
module sdram_arbit_rr #(
   parameter int NUM_CH      = 2,
   parameter int ADDR_W      = 12,
   parameter int BANK_W      = 2,
   parameter int DQ_W        = 16,
   parameter int MAX_GRANT   = 1024,
   localparam int GNT_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     sclk,
   input  logic                     srst_n,
   input  logic                     init_end,
   input  logic [3:0]               init_cmd,
   input  logic [ADDR_W-1:0]        init_addr,
   input  logic                     aref_ask,
   input  logic                     aref_end,
   input  logic [3:0]               aref_cmd,
   input  logic [ADDR_W-1:0]        aref_addr,
   output logic                     aref_en,
   input  logic [NUM_CH-1:0]        ch_ask,
   input  logic [NUM_CH-1:0]        ch_end,
   input  logic [4*NUM_CH-1:0]      ch_cmd,
   input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
   input  logic [BANK_W*NUM_CH-1:0] ch_bank,
   input  logic [DQ_W*NUM_CH-1:0]   ch_wdata,
   input  logic [NUM_CH-1:0]        ch_oe,
   output logic [NUM_CH-1:0]        ch_en,
   output logic [3:0]               sdram_cmd,
   output logic [ADDR_W-1:0]        sdram_addr,
   output logic [BANK_W-1:0]        sdram_bank,
   output logic [DQ_W-1:0]          sdram_dq_out,
   output logic                     sdram_dq_oe,
   output logic [GNT_W-1:0]         gnt_id,
   output logic                     abort_err
);

   localparam int         WD_W    = (MAX_GRANT > 2) ? $clog2(MAX_GRANT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_GRANT - 1);
   localparam logic [3:0] CMD_NOP = 4'b0111;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_ARBIT = 2'd1,
      ST_AREF  = 2'd2,
      ST_GRANT = 2'd3
   } state_t;

   state_t            state_q;
   logic [GNT_W-1:0]  rr_q;
   logic [GNT_W-1:0]  gnt_q;
   logic [WD_W-1:0]   wdog_q;
   logic              abort_q;

   logic [3:0]        cmd_q,  cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BANK_W-1:0] bank_q, bank_d;
   logic [DQ_W-1:0]   dq_q,   dq_d;
   logic              oe_q,   oe_d;

   logic              pick_found;
   logic [GNT_W-1:0]  pick_id;
   logic [GNT_W-1:0]  rr_next;

   // Round-robin search starting at rr_q, wrapping modulo NUM_CH.
   always_comb begin
      int               idx;
      logic [GNT_W-1:0] idx_w;
      pick_found = 1'b0;
      pick_id    = '0;
      idx        = 0;
      idx_w      = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NUM_CH) begin
            idx = idx - NUM_CH;
         end
         idx_w = GNT_W'(idx);
         if (!pick_found && ch_ask[idx_w]) begin
            pick_found = 1'b1;
            pick_id    = idx_w;
         end
      end
   end

   assign rr_next = (gnt_q == GNT_W'(NUM_CH - 1)) ? '0 : gnt_q + 1'b1;

   always_comb begin
      cmd_d  = CMD_NOP;
      addr_d = '0;
      bank_d = '0;
      dq_d   = '0;
      oe_d   = 1'b0;
      case (state_q)
         ST_INIT: begin
            cmd_d  = init_cmd;
            addr_d = init_addr;
         end
         ST_AREF: begin
            cmd_d  = aref_cmd;
            addr_d = aref_addr;
         end
         ST_GRANT: begin
            cmd_d  = ch_cmd[int'(gnt_q)*4 +: 4];
            addr_d = ch_addr[int'(gnt_q)*ADDR_W +: ADDR_W];
            bank_d = ch_bank[int'(gnt_q)*BANK_W +: BANK_W];
            dq_d   = ch_wdata[int'(gnt_q)*DQ_W +: DQ_W];
            oe_d   = ch_oe[gnt_q];
         end
         default: ;
      endcase
   end

   always_ff @(posedge sclk) begin
      if (!srst_n) begin
         state_q <= ST_INIT;
         rr_q    <= '0;
         gnt_q   <= '0;
         wdog_q  <= '0;
         abort_q <= 1'b0;
         cmd_q   <= CMD_NOP;
         addr_q  <= '0;
         bank_q  <= '0;
         dq_q    <= '0;
         oe_q    <= 1'b0;
      end else begin
         abort_q <= 1'b0;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         bank_q  <= bank_d;
         dq_q    <= dq_d;
         oe_q    <= oe_d;
         case (state_q)
            ST_INIT: begin
               if (init_end) state_q <= ST_ARBIT;
            end
            ST_ARBIT: begin
               if (aref_ask) begin
                  state_q <= ST_AREF;
               end else if (pick_found) begin
                  state_q <= ST_GRANT;
                  gnt_q   <= pick_id;
                  wdog_q  <= '0;
               end
            end
            ST_AREF: begin
               if (aref_end) state_q <= ST_ARBIT;
            end
            ST_GRANT: begin
               // A genuine end on the watchdog's last cycle wins over the abort.
               if (ch_end[gnt_q]) begin
                  state_q <= ST_ARBIT;
                  rr_q    <= rr_next;
               end else if (wdog_q == WD_LAST) begin
                  state_q <= ST_ARBIT;
                  rr_q    <= rr_next;
                  abort_q <= 1'b1;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
            end
            default: state_q <= ST_INIT;
         endcase
      end
   end

   always_comb begin
      ch_en = '0;
      if (state_q == ST_GRANT && !aref_ask) begin
         ch_en[gnt_q] = 1'b1;
      end
   end

   assign aref_en      = (state_q == ST_AREF);
   assign sdram_cmd    = cmd_q;
   assign sdram_addr   = addr_q;
   assign sdram_bank   = bank_q;
   assign sdram_dq_out = dq_q;
   assign sdram_dq_oe  = oe_q;
   assign gnt_id       = gnt_q;
   assign abort_err    = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbit_rr.sv
`default_nettype none
// tb_sdram_arbit_rr : randomized scoreboard bench for sdram_arbit_rr with an
// owner-based reference model.
module tb_sdram_arbit_rr;

   localparam int N  = 3;
   localparam int AW = 12;
   localparam int BW = 2;
   localparam int DW = 16;
   localparam int MG = 8;
   localparam int GW = 2;

   localparam int OWN_INIT = -2;
   localparam int OWN_IDLE = -1;
   localparam int OWN_REF  = -3;

   logic            sclk = 1'b0;
   logic            srst_n = 1'b0;
   logic            init_end = 1'b0;
   logic [3:0]      init_cmd = 4'b0111;
   logic [AW-1:0]   init_addr = '0;
   logic            aref_ask = 1'b0;
   logic            aref_end = 1'b0;
   logic [3:0]      aref_cmd = 4'b0111;
   logic [AW-1:0]   aref_addr = '0;
   logic            aref_en;
   logic [N-1:0]    ch_ask = '0;
   logic [N-1:0]    ch_end = '0;
   logic [4*N-1:0]  ch_cmd = '0;
   logic [AW*N-1:0] ch_addr = '0;
   logic [BW*N-1:0] ch_bank = '0;
   logic [DW*N-1:0] ch_wdata = '0;
   logic [N-1:0]    ch_oe = '0;
   logic [N-1:0]    ch_en;
   logic [3:0]      sdram_cmd;
   logic [AW-1:0]   sdram_addr;
   logic [BW-1:0]   sdram_bank;
   logic [DW-1:0]   sdram_dq_out;
   logic            sdram_dq_oe;
   logic [GW-1:0]   gnt_id;
   logic            abort_err;

   always #5 sclk = ~sclk;

   sdram_arbit_rr #(
      .NUM_CH(N), .ADDR_W(AW), .BANK_W(BW), .DQ_W(DW), .MAX_GRANT(MG)
   ) dut (
      .sclk(sclk), .srst_n(srst_n),
      .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
      .aref_ask(aref_ask), .aref_end(aref_end), .aref_cmd(aref_cmd),
      .aref_addr(aref_addr), .aref_en(aref_en),
      .ch_ask(ch_ask), .ch_end(ch_end), .ch_cmd(ch_cmd), .ch_addr(ch_addr),
      .ch_bank(ch_bank), .ch_wdata(ch_wdata), .ch_oe(ch_oe), .ch_en(ch_en),
      .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
      .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
      .gnt_id(gnt_id), .abort_err(abort_err)
   );

   typedef struct {
      logic [3:0]    cmd;
      logic [AW-1:0] addr;
      logic [BW-1:0] bank;
      logic [DW-1:0] dq;
      logic          oe;
      logic [GW-1:0] gnt;
      logic          abort;
   } pins_t;

   typedef struct {
      logic [N-1:0] en;
      logic         aen;
   } comb_t;

   pins_t qp[$];
   comb_t qc[$];

   int total = 0;
   int bad   = 0;

   // Reference model: who owns the pins, and for how many cycles a client has held them.
   int m_own   = OWN_INIT;
   int m_rr    = 0;
   int m_last  = 0;
   int m_held  = 0;
   bit m_valid = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   task automatic model_step();
      comb_t c;
      pins_t p;
      c.en  = '0;
      c.aen = (m_own == OWN_REF);
      if (m_own >= 0 && !aref_ask) c.en[m_own] = 1'b1;
      if (m_valid) qc.push_back(c);

      p.cmd = 4'b0111; p.addr = '0; p.bank = '0; p.dq = '0; p.oe = 1'b0; p.abort = 1'b0;
      if (!srst_n) begin
         m_own = OWN_INIT; m_rr = 0; m_last = 0; m_held = 0; m_valid = 1'b1;
      end else if (m_valid) begin
         if (m_own == OWN_INIT) begin
            p.cmd = init_cmd; p.addr = init_addr;
            if (init_end) m_own = OWN_IDLE;
         end else if (m_own == OWN_REF) begin
            p.cmd = aref_cmd; p.addr = aref_addr;
            if (aref_end) m_own = OWN_IDLE;
         end else if (m_own == OWN_IDLE) begin
            if (aref_ask) begin
               m_own = OWN_REF;
            end else begin
               for (int k = 0; k < N; k++) begin
                  int cand;
                  cand = (m_rr + k) % N;
                  if (ch_ask[cand]) begin
                     m_own = cand; m_last = cand; m_held = 0;
                     break;
                  end
               end
            end
         end else begin
            p.cmd  = ch_cmd[4*m_own +: 4];
            p.addr = ch_addr[AW*m_own +: AW];
            p.bank = ch_bank[BW*m_own +: BW];
            p.dq   = ch_wdata[DW*m_own +: DW];
            p.oe   = ch_oe[m_own];
            m_held++;
            if (ch_end[m_own]) begin
               m_rr = (m_own + 1) % N; m_own = OWN_IDLE;
            end else if (m_held == MG) begin
               p.abort = 1'b1;
               m_rr = (m_own + 1) % N; m_own = OWN_IDLE;
            end
         end
      end
      p.gnt = GW'(m_last);
      if (m_valid) qp.push_back(p);
   endtask

   task automatic randomize_data();
      init_cmd  = 4'($urandom);
      init_addr = AW'($urandom);
      aref_cmd  = 4'($urandom);
      aref_addr = AW'($urandom);
      ch_cmd    = (4*N)'($urandom);
      ch_addr   = (AW*N)'({$urandom, $urandom});
      ch_bank   = (BW*N)'($urandom);
      ch_wdata  = (DW*N)'({$urandom, $urandom});
      ch_oe     = N'($urandom);
   endtask

   // Driver: inputs change on the falling edge, model advances for the next rising edge.
   initial begin
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge sclk);
         randomize_data();
         if (cyc < 3) begin
            srst_n = 1'b0; init_end = 1'b0;
         end else if (cyc < 23) begin
            srst_n = 1'b1; init_end = 1'b0; init_cmd = 4'b0010;
         end else if (cyc == 23) begin
            init_end = 1'b1;
         end else begin
            srst_n   = ($urandom_range(0, 599) != 0);
            init_end = ($urandom_range(0, 3) == 0);
            aref_ask = ($urandom_range(0, 9) == 0);
            aref_end = ($urandom_range(0, 3) == 0);
            ch_ask   = N'($urandom);
            for (int i = 0; i < N; i++) ch_end[i] = ($urandom_range(0, 5) == 0);
         end
         #1;
         model_step();
      end
      repeat (3) @(negedge sclk);
      chk("queues_drained", 64'(qp.size() + qc.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Monitor: enables checked mid-cycle, registered pins checked just after the rising edge.
   initial begin
      comb_t c;
      pins_t p;
      forever begin
         @(negedge sclk);
         #2;
         if (qc.size() > 0) begin
            c = qc.pop_front();
            chk("ch_en", 64'(ch_en), 64'(c.en));
            chk("aref_en", 64'(aref_en), 64'(c.aen));
         end
         @(posedge sclk);
         #1;
         if (qp.size() > 0) begin
            p = qp.pop_front();
            chk("sdram_cmd", 64'(sdram_cmd), 64'(p.cmd));
            chk("sdram_addr", 64'(sdram_addr), 64'(p.addr));
            chk("sdram_bank", 64'(sdram_bank), 64'(p.bank));
            chk("sdram_dq_out", 64'(sdram_dq_out), 64'(p.dq));
            chk("sdram_dq_oe", 64'(sdram_dq_oe), 64'(p.oe));
            chk("gnt_id", 64'(gnt_id), 64'(p.gnt));
            chk("abort_err", 64'(abort_err), 64'(p.abort));
         end
      end
   end

endmodule
`default_nettype wire
